// File: rtl/hv_bundle_threshold_if.sv
// Handshake bundle between the bundler and its neighbours: the input vector
// stream from the accumulator side and the majority-vote output stream.
interface hv_bundle_threshold_if #(
    parameter int D  = 16,
    parameter int CW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [D-1:0]  in_hv;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [D-1:0]  out_hv;
    logic [CW-1:0] out_n;
    logic          out_sat;

    modport master (
        output in_valid, in_hv, in_last, out_ready,
        input  in_ready, out_valid, out_hv, out_n, out_sat
    );

    modport slave (
        input  in_valid, in_hv, in_last, out_ready,
        output in_ready, out_valid, out_hv, out_n, out_sat
    );
endinterface

// File: rtl/hv_bundle_threshold.sv
// Bundles a stream of binary hypervectors into one majority-vote hypervector,
// with per-dimension popcounts, count-saturation close and a clr abort.
module hv_bundle_threshold #(
    parameter int D       = 16,
    parameter int CW      = 8,
    parameter int TIE_ONE = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    hv_bundle_threshold_if.slave   bus
);
    typedef enum logic {ACCUM, EMIT} state_t;

    state_t        state;
    logic [CW-1:0] cnt [D];
    logic [CW-1:0] n;
    logic          sat;

    logic          in_ready_r;
    logic          out_valid_r;
    logic [D-1:0]  out_hv_r;
    logic [CW-1:0] out_n_r;
    logic          out_sat_r;

    logic          accept;
    logic          take;
    logic [CW-1:0] n_inc;
    logic          n_full;
    logic          close;
    logic [CW-1:0] cnt_nxt [D];
    logic [D-1:0]  maj_nxt;

    // Majority over CW+1 bits so 2*cnt never wraps; ties resolve to TIE_ONE.
    function automatic logic majority(input logic [CW-1:0] c, input logic [CW-1:0] total);
        logic [CW:0] twice_c;
        logic [CW:0] tot;
        twice_c = {c, 1'b0};
        tot     = {1'b0, total};
        if (twice_c > tot) return 1'b1;
        if (twice_c < tot) return 1'b0;
        return (TIE_ONE != 0);
    endfunction

    assign accept = bus.in_valid & in_ready_r;
    assign take   = out_valid_r & bus.out_ready;
    assign n_inc  = n + CW'(1);
    assign n_full = (n_inc == {CW{1'b1}});
    assign close  = accept & (bus.in_last | n_full);

    // The output vector is computed from the post-accept counts so it can be
    // registered on the same edge that closes the bundle.
    always_comb begin
        maj_nxt = '0;
        for (int i = 0; i < D; i++) begin
            cnt_nxt[i] = cnt[i] + CW'(bus.in_hv[i]);
            maj_nxt[i] = majority(cnt_nxt[i], n_inc);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ACCUM;
            for (int i = 0; i < D; i++) cnt[i] <= '0;
            n           <= '0;
            sat         <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_hv_r    <= '0;
            out_n_r     <= '0;
            out_sat_r   <= 1'b0;
        end else if (clr) begin
            state       <= ACCUM;
            for (int i = 0; i < D; i++) cnt[i] <= '0;
            n           <= '0;
            sat         <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_hv_r    <= '0;
            out_n_r     <= '0;
            out_sat_r   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        for (int i = 0; i < D; i++) cnt[i] <= cnt_nxt[i];
                        n <= n_inc;
                    end
                    if (close) begin
                        state       <= EMIT;
                        sat         <= ~bus.in_last;
                        in_ready_r  <= 1'b0;
                        out_valid_r <= 1'b1;
                        out_hv_r    <= maj_nxt;
                        out_n_r     <= n_inc;
                        out_sat_r   <= ~bus.in_last;
                    end
                end
                EMIT: begin
                    // Everything stays frozen until the downstream takes the vector.
                    if (take) begin
                        state       <= ACCUM;
                        for (int i = 0; i < D; i++) cnt[i] <= '0;
                        n           <= '0;
                        sat         <= 1'b0;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                        out_hv_r    <= '0;
                        out_n_r     <= '0;
                        out_sat_r   <= 1'b0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_hv    = out_hv_r;
    assign bus.out_n     = out_n_r;
    assign bus.out_sat   = out_sat_r;

    logic unused_sat;
    assign unused_sat = sat;
endmodule
